// File: rtl/cr_fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side stage.
//   cr_fifo_rd_occ_e       occupancy of the two-entry output skid (main + skid register)
//   CR_FIFO_RD_SKID_DEPTH  number of words the stage can hold
//   occ_count()            number of words held for a given occupancy state
package cr_fifo_rd_pkg;

    typedef enum logic [1:0] {
        OCC_ZERO,
        OCC_ONE,
        OCC_TWO
    } cr_fifo_rd_occ_e;

    localparam int unsigned CR_FIFO_RD_SKID_DEPTH = 2;

    function automatic int unsigned occ_count(input cr_fifo_rd_occ_e occ);
        case (occ)
            OCC_ONE: return 1;
            OCC_TWO: return 2;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cr_sat_cnt.sv
// Saturating event counter: counts cycles with inc=1 and sticks at all-ones.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset, clears the count
//   inc    count enable for this cycle
//   cnt    current count
module cr_sat_cnt #(
    parameter int CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc,
    output logic [CNT_BITS-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cr_fifo_rd_stage.sv
// Read-side stage behind a show-ahead FIFO. Pops the FIFO head and presents it on a
// fully registered valid/ready stream. A two-entry skid (main + skid register) gives
// one word per cycle without any combinational path from out_ready to fifo_ren or
// from fifo_rdata to out_data.
// Build option: define CR_FIFO_RD_STATS_EN to add the pop_cnt/stall_cnt counters.
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   fifo_empty  upstream FIFO empty
//   fifo_rdata  upstream FIFO head word, valid while fifo_empty=0
//   fifo_ren    pop strobe to the upstream FIFO (combinational from state only)
//   clear       synchronous flush of the held words; the FIFO is not touched
//   out_valid   output word valid (registered)
//   out_data    output word (registered)
//   out_ready   consumer accepts when out_valid & out_ready
//   idle        stage holds no words
//   pop_cnt     saturating count of pops (CR_FIFO_RD_STATS_EN only)
//   stall_cnt   saturating count of out_valid & ~out_ready cycles (CR_FIFO_RD_STATS_EN only)
module cr_fifo_rd_stage
    import cr_fifo_rd_pkg::*;
#(
    parameter int N_DATA_BITS = 64,
    parameter int CNT_BITS    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    input  logic [N_DATA_BITS-1:0] fifo_rdata,
    output logic                   fifo_ren,
    input  logic                   clear,
    output logic                   out_valid,
    output logic [N_DATA_BITS-1:0] out_data,
    input  logic                   out_ready,
    output logic                   idle
`ifdef CR_FIFO_RD_STATS_EN
    ,
    output logic [CNT_BITS-1:0]    pop_cnt,
    output logic [CNT_BITS-1:0]    stall_cnt
`endif
);

    cr_fifo_rd_occ_e        occ_q, occ_d;
    logic [N_DATA_BITS-1:0] main_q, main_d;
    logic [N_DATA_BITS-1:0] skid_q, skid_d;
    logic                   valid_q, valid_d;
    logic                   pop;
    logic                   take;

    // The pop decision looks only at the registered occupancy, so out_ready never
    // reaches the FIFO combinationally; a free slot must exist before we pop.
    assign fifo_ren = ~fifo_empty & ~clear & (occ_count(occ_q) < CR_FIFO_RD_SKID_DEPTH);
    assign pop      = fifo_ren;
    assign take     = valid_q & out_ready;

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign idle      = (occ_q == OCC_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q   <= OCC_ZERO;
            main_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            valid_q <= valid_d;
        end
    end

    // The main register always holds the oldest word; the skid register only fills
    // when a word arrives while the consumer is stalled. clear overrides the
    // occupancy but leaves the data registers alone since out_valid drops anyway.
    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        case (occ_q)
            OCC_ZERO: begin
                if (pop) begin
                    occ_d  = OCC_ONE;
                    main_d = fifo_rdata;
                end
            end
            OCC_ONE: begin
                if (pop && take) begin
                    main_d = fifo_rdata;
                end else if (pop) begin
                    occ_d  = OCC_TWO;
                    skid_d = fifo_rdata;
                end else if (take) begin
                    occ_d = OCC_ZERO;
                end
            end
            OCC_TWO: begin
                if (take) begin
                    occ_d  = OCC_ONE;
                    main_d = skid_q;
                end
            end
            default: begin
                occ_d = OCC_ZERO;
            end
        endcase
        if (clear) begin
            occ_d = OCC_ZERO;
        end
        valid_d = (occ_d != OCC_ZERO);
    end

`ifdef CR_FIFO_RD_STATS_EN
    cr_sat_cnt #(
        .CNT_BITS(CNT_BITS)
    ) u_pop_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (pop),
        .cnt  (pop_cnt)
    );

    cr_sat_cnt #(
        .CNT_BITS(CNT_BITS)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (valid_q & ~out_ready),
        .cnt  (stall_cnt)
    );
`else
    // CNT_BITS only sizes the statistics counters; it stays a parameter so both
    // builds share one parameter list.
    if (CNT_BITS < 1) begin : g_cnt_bits_unused
    end
`endif

endmodule

// File: tb/tb_cr_fifo_rd_stage.sv
// Self-checking bench for cr_fifo_rd_stage. A queue models the upstream show-ahead
// FIFO; every word written into it is also pushed to a scoreboard. A monitor on the
// falling edge tracks how many words the stage should hold, checks the handshake
// outputs against that count and pops/compares the scoreboard on each transfer.
// Works with or without CR_FIFO_RD_STATS_EN.
module tb_cr_fifo_rd_stage;

    localparam int DW = 32;
`ifdef CR_FIFO_RD_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 32;
`endif

    logic          clk;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata;
    logic          fifo_ren;
    logic          clear;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          idle;
`ifdef CR_FIFO_RD_STATS_EN
    logic [CW-1:0] pop_cnt;
    logic [CW-1:0] stall_cnt;
`endif

    int tests;
    int fails;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            inflight;
    logic          pop_pending;
    logic          hold_prev;
    logic [DW-1:0] prev_data;
    int            pop_model;
    int            stall_model;

    cr_fifo_rd_stage #(
        .N_DATA_BITS(DW),
        .CNT_BITS   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_ren  (fifo_ren),
        .clear     (clear),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .idle      (idle)
`ifdef CR_FIFO_RD_STATS_EN
        ,
        .pop_cnt   (pop_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus: retire last cycle's pop from the FIFO model,
    // write new words into FIFO + scoreboard, then drive the inputs.
    task automatic applyStimulus(input logic rdy, input logic clr, input int n_push,
                                 input logic rstn);
        logic [DW-1:0] w;
        @(posedge clk);
        #1;
        if (pop_pending && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
        end
        for (int i = 0; i < n_push; i++) begin
            w = $urandom;
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        out_ready  = rdy;
        clear      = clr;
        rst_n      = rstn;
        fifo_empty = (fifo_q.size() == 0);
        fifo_rdata = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    // Monitor: the stage holds 'inflight' words; it may pop only with a free slot,
    // presents a word whenever it holds one, and delivers in scoreboard order.
    always @(negedge clk) begin
        logic          exp_ren;
        logic          take;
        logic          stall;
        logic [DW-1:0] w;
        if (!rst_n) begin
            for (int i = 0; i < inflight; i++) begin
                if (exp_q.size() > 0) w = exp_q.pop_front();
            end
            inflight    = 0;
            pop_pending = 1'b0;
            hold_prev   = 1'b0;
            pop_model   = 0;
            stall_model = 0;
        end else begin
            exp_ren = !fifo_empty && (inflight < 2) && !clear;
            take    = (inflight > 0) && out_ready;
            stall   = (inflight > 0) && !out_ready;
            checkOutput("fifo_ren", 64'(fifo_ren), 64'(exp_ren));
            checkOutput("out_valid", 64'(out_valid), 64'(inflight > 0));
            checkOutput("idle", 64'(idle), 64'(inflight == 0));
            if (hold_prev) begin
                checkOutput("stable_data", 64'(out_data), 64'(prev_data));
            end
            if (take) begin
                if (exp_q.size() == 0) begin
                    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd1);
                end else begin
                    w = exp_q.pop_front();
                    checkOutput("out_data", 64'(out_data), 64'(w));
                end
            end
`ifdef CR_FIFO_RD_STATS_EN
            checkOutput("pop_cnt", 64'(pop_cnt), 64'(pop_model));
            checkOutput("stall_cnt", 64'(stall_cnt), 64'(stall_model));
            if (exp_ren && pop_model < (1 << CW) - 1) pop_model++;
            if (stall && stall_model < (1 << CW) - 1) stall_model++;
`endif
            hold_prev   = stall && !clear;
            prev_data   = out_data;
            pop_pending = fifo_ren;
            inflight    = inflight + (fifo_ren ? 1 : 0) - (take ? 1 : 0);
            if (clear) begin
                for (int i = 0; i < inflight; i++) begin
                    if (exp_q.size() > 0) w = exp_q.pop_front();
                end
                inflight = 0;
            end
        end
    end

    initial begin
        int pushed;
        int cycles;
        tests       = 0;
        fails       = 0;
        inflight    = 0;
        pop_pending = 1'b0;
        hold_prev   = 1'b0;
        prev_data   = '0;
        pop_model   = 0;
        stall_model = 0;
        out_ready   = 1'b0;
        clear       = 1'b0;
        fifo_empty  = 1'b1;
        fifo_rdata  = '0;
        rst_n       = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_data", 64'(out_data), 64'd0);
        checkOutput("reset_idle", 64'(idle), 64'd1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);

        // Streaming: eight words, consumer always ready.
        applyStimulus(1'b1, 1'b0, 8, 1'b1);
        repeat (12) applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("stream_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: five words, consumer stalled -> exactly two pops.
        applyStimulus(1'b0, 1'b0, 5, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("bp_fifo_left", 64'(fifo_q.size()), 64'd3);
        repeat (10) applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("bp_drained", 64'(exp_q.size()), 64'd0);

        // clear while full with more words waiting upstream.
        applyStimulus(1'b0, 1'b0, 6, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        repeat (10) applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("clear_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while one word is held.
        applyStimulus(1'b0, 1'b0, 1, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        #1;
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_data", 64'(out_data), 64'd0);
        checkOutput("rst_idle", 64'(idle), 64'd1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3, 1'b1);
        repeat (8) applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("rst_resume_drained", 64'(exp_q.size()), 64'd0);

        // Random fill, random ready, occasional clear.
        pushed = 0;
        cycles = 0;
        while (pushed < 10000 && cycles < 60000) begin
            int n;
            n = (fifo_q.size() < 4) ? int'($urandom_range(0, 2)) : 0;
            if (pushed + n > 10000) n = 10000 - pushed;
            pushed += n;
            cycles++;
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0), n, 1'b1);
        end
        checkOutput("random_budget", 64'(pushed), 64'd10000);
        repeat (20) applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("random_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("random_fifo_empty", 64'(fifo_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
